inst_encoder: RTL and testbench

Inverse of the core's instruction decoder. It takes decoded fields (optype, rs1, rs2, rd, imm) and packs them into RV32I machine words. It checks field legality, tags each word with a sequential byte address, and buffers it in a small output FIFO. It feeds the instruction-memory loader in self-test and program-generation benches, and the on-chip patch path.

---
 rtl/inst_encoder.sv | 229 ++++++++++++++++++++++
 tb/tb_inst_encoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into machine words, checks
// field legality, tags each word with a byte address and buffers it in a FIFO.
package inst_encoder_pkg;
  localparam logic [5:0] OP_NOP  = 6'd0,  OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL  = 6'd3;
  localparam logic [5:0] OP_JALR = 6'd4,  OP_BEQ  = 6'd5,  OP_BNE   = 6'd6,  OP_BLT  = 6'd7;
  localparam logic [5:0] OP_BGE  = 6'd8,  OP_BLTU = 6'd9,  OP_BGEU  = 6'd10, OP_LB   = 6'd11;
  localparam logic [5:0] OP_LH   = 6'd12, OP_LW   = 6'd13, OP_LBU   = 6'd14, OP_LHU  = 6'd15;
  localparam logic [5:0] OP_SB   = 6'd16, OP_SH   = 6'd17, OP_SW    = 6'd18, OP_ADDI = 6'd19;
  localparam logic [5:0] OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22, OP_ORI  = 6'd23;
  localparam logic [5:0] OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI  = 6'd26, OP_SRAI = 6'd27;
  localparam logic [5:0] OP_ADD  = 6'd28, OP_SUB  = 6'd29, OP_SLL   = 6'd30, OP_SLT  = 6'd31;
  localparam logic [5:0] OP_SLTU = 6'd32, OP_XOR  = 6'd33, OP_SRL   = 6'd34, OP_SRA  = 6'd35;
  localparam logic [5:0] OP_OR   = 6'd36, OP_AND  = 6'd37;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } word_t;
endpackage

module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_optype,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [31:0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    F_BAD, F_LUI, F_AUIPC, F_JAL, F_JALR, F_BR, F_LD, F_ST, F_ALUI, F_SHI, F_R
  } fmt_e;

  fmt_e        fmt;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] enc_word;
  logic [1:0]  enc_code;
  logic        i_ok, b_ok, j_ok;

  logic              s1_valid_q, s1_valid_d;
  word_t             s1_q, s1_d;
  word_t             mem_q [DEPTH];
  word_t             mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [31:0]       next_addr_q, next_addr_d, count_q, count_d;
  logic              err_valid_q, err_valid_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              fifo_full, accept, push, pop;

  assign i_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign b_ok = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign j_ok = (&in_imm[31:20]) || !(|in_imm[31:20]);

  // Optype -> format and function fields
  always_comb begin
    fmt = F_BAD;
    f3  = 3'b000;
    f7  = 7'b0000000;
    case (in_optype)
      OP_LUI:   fmt = F_LUI;
      OP_AUIPC: fmt = F_AUIPC;
      OP_JAL:   fmt = F_JAL;
      OP_JALR:  fmt = F_JALR;
      OP_BEQ:   begin fmt = F_BR;   f3 = 3'b000; end
      OP_BNE:   begin fmt = F_BR;   f3 = 3'b001; end
      OP_BLT:   begin fmt = F_BR;   f3 = 3'b100; end
      OP_BGE:   begin fmt = F_BR;   f3 = 3'b101; end
      OP_BLTU:  begin fmt = F_BR;   f3 = 3'b110; end
      OP_BGEU:  begin fmt = F_BR;   f3 = 3'b111; end
      OP_LB:    begin fmt = F_LD;   f3 = 3'b000; end
      OP_LH:    begin fmt = F_LD;   f3 = 3'b001; end
      OP_LW:    begin fmt = F_LD;   f3 = 3'b010; end
      OP_LBU:   begin fmt = F_LD;   f3 = 3'b100; end
      OP_LHU:   begin fmt = F_LD;   f3 = 3'b101; end
      OP_SB:    begin fmt = F_ST;   f3 = 3'b000; end
      OP_SH:    begin fmt = F_ST;   f3 = 3'b001; end
      OP_SW:    begin fmt = F_ST;   f3 = 3'b010; end
      OP_ADDI:  begin fmt = F_ALUI; f3 = 3'b000; end
      OP_SLTI:  begin fmt = F_ALUI; f3 = 3'b010; end
      OP_SLTIU: begin fmt = F_ALUI; f3 = 3'b011; end
      OP_XORI:  begin fmt = F_ALUI; f3 = 3'b100; end
      OP_ORI:   begin fmt = F_ALUI; f3 = 3'b110; end
      OP_ANDI:  begin fmt = F_ALUI; f3 = 3'b111; end
      OP_SLLI:  begin fmt = F_SHI;  f3 = 3'b001; end
      OP_SRLI:  begin fmt = F_SHI;  f3 = 3'b101; end
      OP_SRAI:  begin fmt = F_SHI;  f3 = 3'b101; f7 = 7'b0100000; end
      OP_ADD:   begin fmt = F_R;    f3 = 3'b000; end
      OP_SUB:   begin fmt = F_R;    f3 = 3'b000; f7 = 7'b0100000; end
      OP_SLL:   begin fmt = F_R;    f3 = 3'b001; end
      OP_SLT:   begin fmt = F_R;    f3 = 3'b010; end
      OP_SLTU:  begin fmt = F_R;    f3 = 3'b011; end
      OP_XOR:   begin fmt = F_R;    f3 = 3'b100; end
      OP_SRL:   begin fmt = F_R;    f3 = 3'b101; end
      OP_SRA:   begin fmt = F_R;    f3 = 3'b101; f7 = 7'b0100000; end
      OP_OR:    begin fmt = F_R;    f3 = 3'b110; end
      OP_AND:   begin fmt = F_R;    f3 = 3'b111; end
      default:  fmt = F_BAD;
    endcase
  end

  // Word assembly and legality; lowest failing code wins
  always_comb begin
    opc      = 7'b0000000;
    enc_word = 32'h0;
    enc_code = 2'd0;
    case (fmt)
      F_LUI:   opc = 7'b0110111;
      F_AUIPC: opc = 7'b0010111;
      F_JAL:   opc = 7'b1101111;
      F_JALR:  opc = 7'b1100111;
      F_BR:    opc = 7'b1100011;
      F_LD:    opc = 7'b0000011;
      F_ST:    opc = 7'b0100011;
      F_ALUI, F_SHI: opc = 7'b0010011;
      F_R:     opc = 7'b0110011;
      default: opc = 7'b0000000;
    endcase
    case (fmt)
      F_LUI, F_AUIPC: enc_word = {in_imm[31:12], in_rd, opc};
      F_JAL:   enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
      F_JALR, F_LD, F_ALUI: enc_word = {in_imm[11:0], in_rs1, f3, in_rd, opc};
      F_SHI:   enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
      F_ST:    enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
      F_BR:    enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
      F_R:     enc_word = {f7, in_rs2, in_rs1, f3, in_rd, opc};
      default: enc_word = 32'h0;
    endcase
    case (fmt)
      F_BAD:   enc_code = 2'd1;
      F_JALR, F_LD, F_ST, F_ALUI: if (!i_ok) enc_code = 2'd2;
      F_SHI:   if (|in_imm[31:5]) enc_code = 2'd2;
      F_BR:    if (!b_ok) enc_code = 2'd2; else if (in_imm[0]) enc_code = 2'd3;
      F_JAL:   if (!j_ok) enc_code = 2'd2; else if (in_imm[0]) enc_code = 2'd3;
      F_LUI, F_AUIPC: if (|in_imm[11:0]) enc_code = 2'd2;
      default: enc_code = 2'd0;
    endcase
  end

  assign fifo_full = (occ_q == OCC_W'(DEPTH));
  assign in_ready  = !rst_in && rdy_in && (!s1_valid_q || !fifo_full);
  assign accept    = in_valid && in_ready;
  assign push      = s1_valid_q && !fifo_full && rdy_in;
  assign pop       = out_valid && out_ready && rdy_in;

  // Stage-1 / FIFO next state
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    next_addr_d = next_addr_q;
    count_d     = count_q;
    err_valid_d = accept && (enc_code != 2'd0);
    err_code_d  = err_code_q;
    if (accept && enc_code != 2'd0) err_code_d = enc_code;
    if (push) begin
      mem_d[wr_ptr_q] = s1_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      count_d         = count_q + 32'd1;
      s1_valid_d      = 1'b0;
    end
    if (accept && enc_code == 2'd0) begin
      s1_d        = '{inst: enc_word, addr: next_addr_q};
      s1_valid_d  = 1'b1;
      next_addr_d = next_addr_q + 32'd4;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      next_addr_q <= BASE_ADDR;
      count_q     <= 32'd0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      next_addr_q <= next_addr_d;
      count_q     <= count_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign out_valid = (occ_q != '0);
  assign out_inst  = mem_q[rd_ptr_q].inst;
  assign out_addr  = mem_q[rd_ptr_q].addr;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign count     = count_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with a range/arithmetic reference model and
// a per-cycle compare process on outputs and error reporting.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1, rdy_in = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, err_valid;
  logic [5:0]  in_optype = 6'd0;
  logic [4:0]  in_rs1 = 5'd0, in_rs2 = 5'd0, in_rd = 5'd0;
  logic [31:0] in_imm = 32'd0, out_inst, out_addr, count;
  logic [1:0]  err_code;

  inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_optype(in_optype), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .err_valid(err_valid), .err_code(err_code), .count(count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, acc_cnt = 0;
  bit mon_en = 1'b0, pend_err = 1'b0;
  logic [1:0]  m_code = 2'd0;
  logic [31:0] m_addr = BASE;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Format kind: 0 bad,1 lui,2 auipc,3 jal,4 jalr,5 branch,6 load,7 store,8 alu-imm,9 shift-imm,10 reg
  function automatic void op_info(input logic [5:0] op, output int k, output int f3, output int f7);
    int br_f3[6] = '{0, 1, 4, 5, 6, 7};
    int ld_f3[5] = '{0, 1, 2, 4, 5};
    int st_f3[3] = '{0, 1, 2};
    int ai_f3[6] = '{0, 2, 3, 4, 6, 7};
    int r_f3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int o = int'(op);
    k = 0; f3 = 0; f7 = 0;
    if (o >= 1 && o <= 4) k = o;
    else if (o >= 5 && o <= 10) begin k = 5; f3 = br_f3[o-5]; end
    else if (o >= 11 && o <= 15) begin k = 6; f3 = ld_f3[o-11]; end
    else if (o >= 16 && o <= 18) begin k = 7; f3 = st_f3[o-16]; end
    else if (o >= 19 && o <= 24) begin k = 8; f3 = ai_f3[o-19]; end
    else if (o >= 25 && o <= 27) begin k = 9; f3 = (o == 25) ? 1 : 5; f7 = (o == 27) ? 32 : 0; end
    else if (o >= 28 && o <= 37) begin k = 10; f3 = r_f3[o-28]; f7 = (o == 29 || o == 35) ? 32 : 0; end
  endfunction

  function automatic logic [1:0] m_code_of(input logic [5:0] op, input logic [31:0] imm);
    int k, f3, f7;
    longint s;
    s = $signed(imm);
    op_info(op, k, f3, f7);
    case (k)
      0: return 2'd1;
      4, 6, 7, 8: return (s < -2048 || s > 2047) ? 2'd2 : 2'd0;
      9: return (imm > 32'd31) ? 2'd2 : 2'd0;
      5: begin if (s < -4096 || s > 4095) return 2'd2; return (imm % 2 != 0) ? 2'd3 : 2'd0; end
      3: begin if (s < -1048576 || s > 1048575) return 2'd2; return (imm % 2 != 0) ? 2'd3 : 2'd0; end
      1, 2: return (imm % 4096 != 0) ? 2'd2 : 2'd0;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_enc(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] d, input logic [31:0] imm);
    int k, f3, f7;
    bit [31:0] u, r1, r2, rd, fn3, fn7, opc, w;
    int opcs[11] = '{0, 'h37, 'h17, 'h6f, 'h67, 'h63, 'h03, 'h23, 'h13, 'h13, 'h33};
    op_info(op, k, f3, f7);
    u = imm; r1 = 32'(a); r2 = 32'(b); rd = 32'(d);
    fn3 = 32'(f3); fn7 = 32'(f7); opc = 32'(opcs[k]);
    case (k)
      1, 2: w = (u & 32'hFFFFF000) | rd << 7 | opc;
      3: w = ((u >> 20) & 1) << 31 | ((u >> 1) & 32'h3FF) << 21 | ((u >> 11) & 1) << 20 |
             ((u >> 12) & 32'hFF) << 12 | rd << 7 | opc;
      4, 6, 8: w = (u & 32'hFFF) << 20 | r1 << 15 | fn3 << 12 | rd << 7 | opc;
      9: w = fn7 << 25 | (u & 31) << 20 | r1 << 15 | fn3 << 12 | rd << 7 | opc;
      7: w = ((u >> 5) & 32'h7F) << 25 | r2 << 20 | r1 << 15 | fn3 << 12 | (u & 31) << 7 | opc;
      5: w = ((u >> 12) & 1) << 31 | ((u >> 5) & 32'h3F) << 25 | r2 << 20 | r1 << 15 | fn3 << 12 |
             ((u >> 1) & 32'hF) << 8 | ((u >> 11) & 1) << 7 | opc;
      10: w = fn7 << 25 | r2 << 20 | r1 << 15 | fn3 << 12 | rd << 7 | opc;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Compare process: outputs sampled on the falling edge, model advanced for the next rising edge
  always @(negedge clk) begin
    logic [1:0] c;
    if (mon_en) begin
      check("err_valid", 32'(err_valid), 32'(pend_err));
      check("err_code", 32'(err_code), 32'(m_code));
      if (out_valid) begin
        check("out_head_exists", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("out_inst", out_inst, exp_q[0][63:32]);
          check("out_addr", out_addr, exp_q[0][31:0]);
        end
      end
      pend_err = 1'b0;
      if (rst_in) begin
        exp_q.delete();
        m_addr = BASE;
        m_code = 2'd0;
      end else begin
        if (out_valid && out_ready && rdy_in && exp_q.size() != 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) begin
          acc_cnt++;
          c = m_code_of(in_optype, in_imm);
          if (c != 2'd0) begin
            pend_err = 1'b1;
            m_code = c;
          end else begin
            exp_q.push_back({m_enc(in_optype, in_rs1, in_rs2, in_rd, in_imm), m_addr});
            m_addr += 32'd4;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic [31:0] imm);
    bit done = 1'b0;
    in_optype = op; in_rs1 = a; in_rs2 = b; in_rd = d; in_imm = imm; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic drain_check(input string name, input logic [31:0] exp_count);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
    tick(1);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_count"}, count, exp_count);
  endtask

  initial begin
    logic [31:0] h_inst, h_addr, h_cnt;
    int acc0;
    tick(1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_count", count, 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    mon_en = 1'b1;
    tick(1);
    rst_in = 1'b0;
    tick(1);

    // Model pins
    check("pin_sw", m_enc(OP_SW, 5'd1, 5'd2, 5'd0, 32'd8), 32'h0020A423);
    check("pin_beq", m_enc(OP_BEQ, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC), 32'hFE208EE3);
    check("pin_srai", m_enc(OP_SRAI, 5'd3, 5'd0, 5'd3, 32'd4), 32'h4041D193);
    check("pin_jal", m_enc(OP_JAL, 5'd0, 5'd0, 5'd1, 32'h800), 32'h001000EF);
    check("pin_code_addi", 32'(m_code_of(OP_ADDI, 32'd2048)), 32'd2);
    check("pin_code_jal", 32'(m_code_of(OP_JAL, 32'd3)), 32'd3);

    // Basic encode and 2-cycle latency
    send(OP_ADDI, 5'd0, 5'd0, 5'd1, 32'd5);
    check("lat_s1_only", 32'(out_valid), 32'd0);
    tick(1);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_inst", out_inst, 32'h00500093);
    check("lat_out_addr", out_addr, BASE);
    send(OP_LUI, 5'd0, 5'd0, 5'd5, 32'h12345000);
    tick(1);
    check("lui_inst", out_inst, 32'h123452B7);
    check("lui_addr", out_addr, BASE + 32'd4);
    drain_check("t1", 32'd2);

    // Store, branch, shift, jump formats
    send(OP_SW, 5'd1, 5'd2, 5'd0, 32'd8);
    send(OP_BEQ, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC);
    send(OP_SRAI, 5'd3, 5'd0, 5'd3, 32'd4);
    send(OP_JAL, 5'd0, 5'd0, 5'd1, 32'h800);
    send(OP_SUB, 5'd7, 5'd9, 5'd4, 32'd0);
    drain_check("t2", 32'd7);

    // Rejections
    send(OP_ADDI, 5'd0, 5'd0, 5'd1, 32'd2048);
    check("err1_valid", 32'(err_valid), 32'd1);
    check("err1_code", 32'(err_code), 32'd2);
    tick(1);
    check("err1_pulse", 32'(err_valid), 32'd0);
    send(OP_JAL, 5'd0, 5'd0, 5'd1, 32'd3);
    check("err2_code", 32'(err_code), 32'd3);
    send(OP_NOP, 5'd0, 5'd0, 5'd0, 32'd0);
    check("err3_code", 32'(err_code), 32'd1);
    send(6'd50, 5'd0, 5'd0, 5'd0, 32'd0);
    send(OP_BNE, 5'd0, 5'd0, 5'd0, 32'h2000);
    tick(2);
    check("err_no_output", 32'(out_valid), 32'd0);
    check("err_count", count, 32'd7);
    check("err_code_held", 32'(err_code), 32'd2);

    // Back-pressure: DEPTH+1 accepts then stall
    out_ready = 1'b0;
    acc0 = acc_cnt;
    for (int i = 0; i < DEPTH + 1; i++) send(OP_ADDI, 5'(i), 5'd0, 5'(i + 1), 32'(i * 10));
    in_optype = OP_ORI; in_rs1 = 5'd2; in_rd = 5'd6; in_imm = 32'hFFFFF800; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
    end
    tick(1);
    check("full_accepts", 32'(acc_cnt - acc0), 32'(DEPTH + 1));
    out_ready = 1'b1;
    send(OP_ORI, 5'd2, 5'd0, 5'd6, 32'hFFFFF800);
    send(OP_SLLI, 5'd2, 5'd0, 5'd6, 32'd31);
    drain_check("t4", 32'd7 + 32'(DEPTH + 3));

    // rdy_in freeze
    out_ready = 1'b0;
    send(OP_AUIPC, 5'd0, 5'd0, 5'd8, 32'hABCDE000);
    send(OP_LW, 5'd3, 5'd0, 5'd9, 32'hFFFFFFF0);
    send(OP_AND, 5'd4, 5'd5, 5'd10, 32'd0);
    tick(2);
    h_inst = out_inst; h_addr = out_addr; h_cnt = count;
    rdy_in = 1'b0; out_ready = 1'b1;
    in_optype = OP_BGEU; in_rs1 = 5'd1; in_rs2 = 5'd2; in_imm = 32'd4094; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("frz_in_ready", 32'(in_ready), 32'd0);
      check("frz_out_valid", 32'(out_valid), 32'd1);
      check("frz_out_inst", out_inst, h_inst);
      check("frz_out_addr", out_addr, h_addr);
      check("frz_count", count, h_cnt);
    end
    tick(1);
    rdy_in = 1'b1;
    send(OP_BGEU, 5'd1, 5'd2, 5'd0, 32'd4094);
    drain_check("t5", 32'd18);

    // Mid-stream reset
    out_ready = 1'b0;
    send(OP_XORI, 5'd1, 5'd0, 5'd2, 32'd1);
    send(OP_SLT, 5'd1, 5'd2, 5'd3, 32'd0);
    tick(2);
    check("pre_rst_count", count, 32'd20);
    rst_in = 1'b1;
    tick(1);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_count", count, 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd0);
    rst_in = 1'b0;
    send(OP_ADDI, 5'd0, 5'd0, 5'd1, 32'd5);
    tick(1);
    check("mrst_addr", out_addr, BASE);
    check("mrst_inst", out_inst, 32'h00500093);
    out_ready = 1'b1;
    drain_check("t6", 32'd1);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
